// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N-channel button synchroniser/debouncer with press, release, long-press and auto-repeat ticks
module btn_debounce_multi #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_tick,
  output logic [N_CH-1:0] release_tick,
  output logic [N_CH-1:0] long_tick,
  output logic [N_CH-1:0] repeat_tick
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2
  } hold_state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              s1, s2;
    logic [DB_W-1:0]   db_cnt, db_cnt_next;
    logic              level_q, level_next;
    hold_state_t       state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic              press_q, release_q, long_q, repeat_q;
    logic              press_next, release_next, long_next, repeat_next;

    // Window restarts on any ce cycle where the synchronised input agrees with level.
    always_comb begin
      db_cnt_next = db_cnt;
      level_next  = level_q;
      if (ce) begin
        if (s2 == level_q) begin
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          level_next  = s2;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
    end

    // Hold FSM reacts to the level update landing this edge, so ticks align with level.
    always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      press_next    = 1'b0;
      release_next  = 1'b0;
      long_next     = 1'b0;
      repeat_next   = 1'b0;
      case (state)
        RELEASED: begin
          if (level_next && !level_q) begin
            state_next    = HELD;
            hold_cnt_next = '0;
            press_next    = 1'b1;
          end
        end
        HELD: begin
          if (!level_next && level_q) begin
            state_next    = RELEASED;
            hold_cnt_next = '0;
            release_next  = 1'b1;
          end else if (ce) begin
            if (hold_cnt == LONG_LAST) begin
              state_next    = REPEAT;
              hold_cnt_next = '0;
              long_next     = 1'b1;
            end else begin
              hold_cnt_next = hold_cnt + HOLD_ONE;
            end
          end
        end
        REPEAT: begin
          if (!level_next && level_q) begin
            state_next    = RELEASED;
            hold_cnt_next = '0;
            release_next  = 1'b1;
          end else if (!repeat_en[i]) begin
            hold_cnt_next = '0;
          end else if (ce) begin
            if (hold_cnt == REP_LAST) begin
              hold_cnt_next = '0;
              repeat_next   = 1'b1;
            end else begin
              hold_cnt_next = hold_cnt + HOLD_ONE;
            end
          end
        end
        default: begin
          state_next    = RELEASED;
          hold_cnt_next = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        db_cnt    <= '0;
        level_q   <= 1'b0;
        state     <= RELEASED;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        s1        <= btn_in[i];
        s2        <= s1;
        db_cnt    <= db_cnt_next;
        level_q   <= level_next;
        state     <= state_next;
        hold_cnt  <= hold_cnt_next;
        press_q   <= press_next;
        release_q <= release_next;
        long_q    <= long_next;
        repeat_q  <= repeat_next;
      end
    end

    assign level[i]        = level_q;
    assign press_tick[i]   = press_q;
    assign release_tick[i] = release_q;
    assign long_tick[i]    = long_q;
    assign repeat_tick[i]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - randomized and directed bench for btn_debounce_multi against a behavioural model
module tb_btn_debounce_multi;
  localparam int N  = 2;
  localparam int DB = 4;
  localparam int LG = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] level, press_tick, release_tick, long_tick, repeat_tick;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int ce_mode = 0;

  btn_debounce_multi #(
    .N_CH(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .btn_in(btn_in), .repeat_en(repeat_en),
    .level(level), .press_tick(press_tick), .release_tick(release_tick),
    .long_tick(long_tick), .repeat_tick(repeat_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (ce_mode)
      0:       ce = 1'b1;
      1:       ce = ((cyc % 4) == 0);
      default: ce = (($urandom % 4) != 0);
    endcase
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (time %0t)", name, got, exp, $time);
  endtask

  // Model: pipeline of two samples, count of consecutive mismatched ce cycles,
  // and a hold phase with elapsed ce-edges since the last event.
  bit m_s1 [N];
  bit m_s2 [N];
  bit m_lvl [N];
  int m_run [N];
  int m_phase [N];
  int m_t [N];
  logic [N-1:0] e_level, e_press, e_release, e_long, e_repeat;
  bit old_lvl, old_s2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0;
        m_run[c] = 0; m_phase[c] = 0; m_t[c] = 0;
      end
      e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        old_lvl = m_lvl[c];
        old_s2  = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = btn_in[c];
        e_press[c] = 0; e_release[c] = 0; e_long[c] = 0; e_repeat[c] = 0;
        if (ce) begin
          if (old_s2 != old_lvl) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
              m_lvl[c] = old_s2;
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
        end
        if (m_lvl[c] && !old_lvl) begin
          e_press[c] = 1; m_phase[c] = 1; m_t[c] = 0;
        end else if (!m_lvl[c] && old_lvl) begin
          e_release[c] = 1; m_phase[c] = 0; m_t[c] = 0;
        end else if (m_phase[c] == 1 && ce) begin
          m_t[c]++;
          if (m_t[c] == LG) begin
            e_long[c] = 1; m_phase[c] = 2; m_t[c] = 0;
          end
        end else if (m_phase[c] == 2) begin
          if (!repeat_en[c]) m_t[c] = 0;
          else if (ce) begin
            m_t[c]++;
            if (m_t[c] == RP) begin
              e_repeat[c] = 1; m_t[c] = 0;
            end
          end
        end
        e_level[c] = m_lvl[c];
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_level", int'(level), int'(e_level));
    check("cmp_press", int'(press_tick), int'(e_press));
    check("cmp_release", int'(release_tick), int'(e_release));
    check("cmp_long", int'(long_tick), int'(e_long));
    check("cmp_repeat", int'(repeat_tick), int'(e_repeat));
    for (int c = 0; c < N; c++)
      check("cmp_onehot", (int'(press_tick[c]) + int'(release_tick[c]) + int'(long_tick[c]) + int'(repeat_tick[c])) <= 1, 1);
  end

  function automatic logic sel(input int which, input int ch);
    case (which)
      0:       return press_tick[ch];
      1:       return release_tick[ch];
      2:       return long_tick[ch];
      default: return repeat_tick[ch];
    endcase
  endfunction

  // Edges counted from the first posedge after the call until the tick shows; -1 on timeout.
  task automatic wait_for(input int which, input int ch, input int limit, output int edges);
    bit found = 0;
    edges = 0;
    while (!found && edges < limit) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (sel(which, ch)) found = 1;
    end
    if (!found) edges = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e;

  initial begin
    idle(3);
    check("reset_outputs", int'({level, press_tick, release_tick, long_tick, repeat_tick}), 0);
    rst_n = 1'b1;
    idle(3);

    // Press latency, long and repeat spacing, release latency.
    repeat_en[0] = 1'b1;
    btn_in[0] = 1'b1;
    wait_for(0, 0, 20, e); check("press_latency", e, 6);
    check("ch1_silent", int'(level[1]), 0);
    wait_for(2, 0, 20, e); check("long_after_press", e, LG);
    wait_for(3, 0, 10, e); check("repeat_first", e, RP);
    wait_for(3, 0, 10, e); check("repeat_second", e, RP);
    idle(1);
    btn_in[0] = 1'b0;
    wait_for(1, 0, 20, e); check("release_latency", e, 6);
    wait_for(3, 0, 10, e); check("no_repeat_after_release", e, -1);

    // Three-cycle glitch is swallowed, four-cycle pulse is accepted.
    btn_in[0] = 1'b1; idle(3); btn_in[0] = 1'b0;
    wait_for(0, 0, 15, e); check("glitch_no_press", e, -1);
    check("glitch_level", int'(level[0]), 0);
    btn_in[0] = 1'b1; idle(4); btn_in[0] = 1'b0;
    wait_for(0, 0, 15, e); check("pulse4_press", e > 0, 1);
    wait_for(1, 0, 20, e); check("pulse4_release", e > 0, 1);
    idle(5);

    // Repeat disabled until mid-REPEAT.
    repeat_en[0] = 1'b0;
    btn_in[0] = 1'b1;
    wait_for(0, 0, 20, e); check("press2_latency", e, 6);
    wait_for(2, 0, 20, e); check("long2_after_press", e, LG);
    wait_for(3, 0, 10, e); check("repeat_disabled", e, -1);
    repeat_en[0] = 1'b1;
    wait_for(3, 0, 10, e); check("repeat_after_enable", e, RP);
    btn_in[0] = 1'b0;
    wait_for(1, 0, 30, e); check("release2_seen", e > 0, 1);
    idle(5);

    // Prescaled timers, ce on every fourth edge.
    ce_mode = 1;
    btn_in[1] = 1'b1;
    wait_for(0, 1, 40, e); check("ce4_press_range", (e >= 15 && e <= 18), 1);
    wait_for(2, 1, 60, e); check("ce4_long", e, 4 * LG);
    btn_in[1] = 1'b0;
    wait_for(1, 1, 60, e); check("ce4_release_seen", e > 0, 1);
    idle(5);

    // Random buttons, repeat enables and ce, checked by the model.
    ce_mode = 2;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (($urandom % 40) == 0) btn_in[c] = ~btn_in[c];
        if (($urandom % 60) == 0) repeat_en[c] = ~repeat_en[c];
      end
    end

    // Reset while both channels are held.
    ce_mode = 0;
    repeat_en = '0;
    btn_in = '1;
    idle(40);
    check("both_held", int'(level), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", int'({level, press_tick, release_tick, long_tick, repeat_tick}), 0);
    idle(2);
    rst_n = 1'b1;
    wait_for(0, 0, 20, e); check("repress_after_reset", e, 6);
    check("repress_ch1", int'(press_tick[1]), 1);
    idle(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
